// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the spiking synapse driver.
package snn_pkg;

  localparam int unsigned WEIGHT_W  = 8;
  localparam int unsigned CURRENT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DECAY = 2'd3
  } state_t;

  typedef struct packed {
    logic                 ovf;
    logic [CURRENT_W-1:0] value;
  } accum_t;

  // Unsigned accumulator plus signed weight, clamped to [0, 2^CURRENT_W-1].
  function automatic accum_t sat_accum(input logic [CURRENT_W-1:0] acc,
                                       input logic [WEIGHT_W-1:0]  w);
    logic signed [CURRENT_W+1:0] sum;
    accum_t r;
    sum = $signed({2'b00, acc}) +
          $signed({{(CURRENT_W+2-WEIGHT_W){w[WEIGHT_W-1]}}, w});
    r.ovf   = 1'b0;
    r.value = sum[CURRENT_W-1:0];
    if (sum[CURRENT_W+1]) begin
      r.value = '0;
    end else if (sum[CURRENT_W]) begin
      r.value = '1;
      r.ovf   = 1'b1;
    end
    return r;
  endfunction

  // Exponential leak; falls back to a unit step so small values still reach zero.
  function automatic logic [CURRENT_W-1:0] decay_step(input logic [CURRENT_W-1:0] a,
                                                      input int unsigned          sh);
    logic [CURRENT_W-1:0] d;
    d = a >> sh;
    if (d != '0)      return a - d;
    else if (a != '0) return a - CURRENT_W'(1);
    else              return '0;
  endfunction

endpackage

// File: rtl/spike_synapse_driver_if.sv
// Spike/weight input bus and neuron-side outputs of the synapse driver.
interface spike_synapse_driver_if
  import snn_pkg::*;
#(
  parameter int unsigned N_PRE = 8
);
  localparam int unsigned AW = (N_PRE > 1) ? $clog2(N_PRE) : 1;

  logic                 spike_valid;
  logic [AW-1:0]        spike_addr;
  logic                 spike_ready;
  logic                 w_we;
  logic [AW-1:0]        w_addr;
  logic [WEIGHT_W-1:0]  w_data;
  logic [CURRENT_W-1:0] current;
  logic                 stop;
  logic                 overflow;

  modport master (
    output spike_valid, spike_addr, w_we, w_addr, w_data,
    input  spike_ready, current, stop, overflow
  );

  modport slave (
    input  spike_valid, spike_addr, w_we, w_addr, w_data,
    output spike_ready, current, stop, overflow
  );
endinterface

// File: rtl/spike_event_fifo.sv
// Spike source-index queue with registered ready/empty flags.
module spike_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             ready,
  output logic             empty,
  output logic             empty_next_c
);
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CNTW-1:0]  count, count_next;
  logic             do_push, do_pop;

  // ready already means "not full", so a same-cycle pop never frees a slot for push
  assign do_push      = push && ready;
  assign do_pop       = pop && !empty;
  assign count_next   = count + CNTW'(do_push) - CNTW'(do_pop);
  assign empty_next_c = (count_next == '0);
  assign dout         = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      ready <= (count_next != CNTW'(DEPTH));
      empty <= (count_next == '0);
    end
  end
endmodule

// File: rtl/spike_synapse_driver.sv
// Turns queued presynaptic spikes into a saturating, leaky synaptic current.
module spike_synapse_driver
  import snn_pkg::*;
#(
  parameter int unsigned N_PRE        = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DECAY_PERIOD = 10,
  parameter int unsigned TAU_SHIFT    = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  spike_synapse_driver_if.slave  bus
);
  localparam int unsigned AW = (N_PRE > 1) ? $clog2(N_PRE) : 1;
  localparam int unsigned CW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

  state_t               state, state_next;
  logic [WEIGHT_W-1:0]  weights [N_PRE];
  logic [WEIGHT_W-1:0]  w_reg;
  logic [CURRENT_W-1:0] acc, acc_next;
  logic                 ovf, ovf_next;
  logic                 pending, pending_next;
  logic [CW-1:0]        dcnt;
  logic                 tc;
  logic                 push, pop;
  logic [AW-1:0]        head;
  logic                 fifo_empty, fifo_empty_next;
  logic                 stop_q;
  accum_t               acc_res;

  assign push = bus.spike_valid && bus.spike_ready;

  spike_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AW)
  ) u_fifo (
    .clk          (clk),
    .rst          (reset_n),
    .push         (push),
    .pop          (pop),
    .din          (bus.spike_addr),
    .dout         (head),
    .ready        (bus.spike_ready),
    .empty        (fifo_empty),
    .empty_next_c (fifo_empty_next)
  );

  // A terminal count landing on the DECAY cycle is absorbed, never queued twice.
  assign tc           = (dcnt == CW'(DECAY_PERIOD - 1));
  assign pending_next = (state == ST_DECAY) ? 1'b0 : (pending | tc);

  always_comb begin
    state_next = state;
    acc_next   = acc;
    ovf_next   = ovf;
    pop        = 1'b0;
    acc_res    = sat_accum(acc, w_reg);
    case (state)
      ST_IDLE: begin
        if (pending)          state_next = ST_DECAY;
        else if (!fifo_empty) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        pop        = 1'b1;
        state_next = ST_ACCUM;
      end
      ST_ACCUM: begin
        acc_next   = acc_res.value;
        ovf_next   = ovf | acc_res.ovf;
        state_next = ST_IDLE;
      end
      ST_DECAY: begin
        acc_next   = decay_step(acc, TAU_SHIFT);
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      ovf     <= 1'b0;
      pending <= 1'b0;
      dcnt    <= '0;
      w_reg   <= '0;
      stop_q  <= 1'b1;
      for (int i = 0; i < int'(N_PRE); i++) weights[i] <= '0;
    end else begin
      state   <= state_next;
      acc     <= acc_next;
      ovf     <= ovf_next;
      pending <= pending_next;
      dcnt    <= tc ? '0 : dcnt + CW'(1);
      // Read before write: a same-edge weight update is not seen by this fetch
      if (state == ST_FETCH) w_reg <= weights[head];
      if (bus.w_we) weights[bus.w_addr] <= bus.w_data;
      stop_q  <= (acc_next == '0) && fifo_empty_next && (state_next == ST_IDLE);
    end
  end

  assign bus.current  = acc;
  assign bus.overflow = ovf;
  assign bus.stop     = stop_q;
endmodule

// File: doc/spike_synapse_driver.md
SPIKE_SYNAPSE_DRIVER -- requirements
Module: spike_synapse_driver

Interface
REQ-001 SHALL have parameter N_PRE, default 8: number of presynaptic sources.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: spike event queue depth (power of 2).
REQ-003 SHALL have parameter DECAY_PERIOD, default 10: clock cycles between decay ticks.
REQ-004 SHALL have parameter TAU_SHIFT, default 3: decay right-shift amount.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port reset_n, input, 1: synchronous active-high reset (asserted = 1, sampled on clk rising edge).
REQ-007 SHALL have port spike_valid, input, 1: presynaptic spike event offered.
REQ-008 SHALL have port spike_addr, input, $clog2(N_PRE): source index of the offered spike.
REQ-009 SHALL have port spike_ready, output, 1: event queue can accept.
REQ-010 SHALL have port w_we, input, 1: weight write enable.
REQ-011 SHALL have port w_addr, input, $clog2(N_PRE): weight index.
REQ-012 SHALL have port w_data, input, 8: signed two's-complement weight.
REQ-013 SHALL have port current, output, 8: unsigned synaptic current to neuron, registered.
REQ-014 SHALL have port stop, output, 1: high when no drive pending (current 0, queue empty, FSM IDLE).
REQ-015 SHALL have port overflow, output, 1: sticky, set on positive saturation.

Function
REQ-016 Event accepted at an edge where spike_valid && spike_ready; spike_addr pushed into FIFO at that edge.
REQ-017 spike_ready SHALL equal !fifo_full; no push while full, even if a pop occurs in the same cycle.
REQ-018 Weight file: N_PRE x 8-bit signed; written at edge when w_we=1; a same-cycle read returns the pre-write value.
REQ-019 Decay counter counts 0..DECAY_PERIOD-1 and wraps; at terminal count it sets decay_pending.
REQ-020 FSM states: IDLE, FETCH, ACCUM, DECAY.
REQ-021 IDLE -> DECAY if decay_pending; else IDLE -> FETCH if FIFO non-empty; else stay IDLE. Decay has priority.
REQ-022 FETCH: pop the FIFO head, latch weight[head] into w_reg, then go to ACCUM.
REQ-023 ACCUM: acc <= sat(acc + w_reg) clamped to [0,255], then go to IDLE.
REQ-024 ACCUM: if the unclamped sum exceeds 255, set overflow; overflow clears only on reset.
REQ-025 DECAY: d = acc >> TAU_SHIFT; acc <= acc - d if d != 0, else acc - 1 if acc != 0, else 0; clear decay_pending; go to IDLE.
REQ-026 A terminal count that occurs while decay_pending is already set SHALL NOT queue a second decay.
REQ-027 current SHALL equal acc, the register updated in ACCUM/DECAY.
REQ-028 With FSM IDLE, FIFO empty and no pending decay, the event accepted at edge k SHALL be visible on current after edge k+3.
REQ-029 Events SHALL be processed in FIFO order; no accepted event is lost or duplicated.

Reset
REQ-030 While reset_n=1 at an edge: acc=0, current=0, overflow=0, FIFO empty, decay counter=0, decay_pending=0, FSM=IDLE, all weights=0.
REQ-031 While reset_n=1: spike_ready=0 and stop=1; after release, spike_ready=1 at the first edge.
REQ-032 Reset mid-operation (any state) SHALL abort in-flight events with no partial acc update.

Structure
REQ-033 Shared package snn_pkg SHALL hold the FSM state encoding, the weight width (8) and the current width (8).
REQ-034 The FIFO SHALL be a sub-module, spike_event_fifo (push/pop/full/empty, depth FIFO_DEPTH).

Verification
REQ-035 Reset, write w[2]=40, one spike on addr 2 at edge k -> current 0 through edge k+2, 40 after k+3; stop 1->0.
REQ-036 acc=40, no events -> successive decays 40->35->31->28; acc=5 -> 4 (d=0 case); decay reaches 0, then stop=1.
REQ-037 w[1]=100, three spikes -> 100, 200, 255 with overflow=1 sticky; then w[0]=-128 from acc 50 -> 0, overflow stays 1.
REQ-038 Eight back-to-back spikes with valid held -> spike_ready drops when FIFO holds 4; all 8 applied in order; final current matches the saturated sum.
REQ-039 decay_pending and non-empty FIFO in the same IDLE cycle -> DECAY executes first, then FETCH/ACCUM.
REQ-040 reset_n=1 during ACCUM -> next edge current=0, FIFO empty, overflow=0; spike_ready=1 one edge after release.
